// File: rtl/ipv4_hdr_chksum_stream.sv
// Streaming IPv4 header checksum engine: sums a header of any length delivered as DW-bit beats,
// folds the one's-complement sum, and reports the checksum (generate) or its validity (verify).
module ipv4_hdr_chksum_stream #(
    parameter int DW        = 32,
    parameter int MAX_BEATS = 15,
    parameter int MIN_BEATS = (160 + DW - 1) / DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    input  logic          in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_chksum,
    output logic          out_ok,
    output logic          out_err
);

    localparam int LANES = DW / 16;
    localparam int ACCW  = 16 + $clog2(MAX_BEATS * LANES + 1);
    localparam int CW    = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_BEATS);
    localparam logic [CW:0]   MIN_C = (CW + 1)'(MIN_BEATS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_FOLD1,
        S_FOLD2,
        S_DONE
    } state_t;

    state_t            state;
    logic [ACCW-1:0]   acc;
    logic [ACCW-1:0]   lane_sum;
    logic [ACCW-1:0]   fold;
    logic [CW-1:0]     cnt;
    logic [CW:0]       cnt_inc;
    logic [15:0]       lane;
    logic [15:0]       sum16;
    logic              mode;
    logic              err;
    logic              accept;
    logic              cur_mode;
    logic              overflow;
    logic              drop;

    assign in_ready = !rst && (state == S_IDLE || state == S_ACCUM);
    assign accept   = in_valid && in_ready;
    // The first beat carries the mode itself; later beats use the latched copy.
    assign cur_mode = (state == S_IDLE) ? in_mode : mode;
    assign cnt_inc  = {1'b0, cnt} + (CW + 1)'(1);
    assign overflow = (cnt == MAX_C);
    assign drop     = err || overflow;
    assign fold     = ACCW'(acc[15:0]) + ACCW'(acc[ACCW-1:16]);
    assign sum16    = fold[15:0];

    // cnt equals the index of the incoming beat, so lane 5 of the header can be located at any DW.
    always_comb begin
        lane     = '0;
        lane_sum = '0;
        for (int p = 0; p < LANES; p++) begin
            lane = in_data[DW-1-16*p -: 16];
            if (!cur_mode && (int'(cnt) * LANES + p == 5)) begin
                lane = '0;
            end
            lane_sum = lane_sum + ACCW'(lane);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            acc        <= '0;
            cnt        <= '0;
            mode       <= 1'b0;
            err        <= 1'b0;
            out_valid  <= 1'b0;
            out_chksum <= '0;
            out_ok     <= 1'b0;
            out_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_ACCUM: begin
                    if (accept) begin
                        if (state == S_IDLE) begin
                            mode <= in_mode;
                        end
                        if (!drop) begin
                            acc <= acc + lane_sum;
                        end
                        if (!overflow) begin
                            cnt <= cnt_inc[CW-1:0];
                        end
                        err   <= drop || (in_last && !overflow && (cnt_inc < MIN_C));
                        state <= in_last ? S_FOLD1 : S_ACCUM;
                    end
                end
                S_FOLD1: begin
                    acc   <= fold;
                    state <= S_FOLD2;
                end
                S_FOLD2: begin
                    acc        <= fold;
                    out_valid  <= 1'b1;
                    out_chksum <= ~sum16;
                    out_ok     <= !err && (!mode || sum16 == 16'hFFFF);
                    out_err    <= err;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                        err       <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ipv4_hdr_chksum_stream.sv
// Testbench for ipv4_hdr_chksum_stream: three instances (DW=32, 16, 64) checked against a
// word-level one's-complement reference model.
module tb_ipv4_hdr_chksum_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv[3];
    logic        il[3];
    logic        im[3];
    logic        ordy[3];
    logic        ir[3];
    logic        ov[3];
    logic        ok_o[3];
    logic        er[3];
    logic [15:0] ck[3];
    logic [31:0] d32;
    logic [15:0] d16;
    logic [63:0] d64;

    int checks = 0;
    int errors = 0;

    logic [15:0] ref_hdr[$] = '{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011,
                                16'hB861, 16'hC0A8, 16'h0001, 16'hC0A8, 16'h00C7};

    always #5 clk = ~clk;

    ipv4_hdr_chksum_stream #(.DW(32)) dut (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(d32),
        .in_last(il[0]), .in_mode(im[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_chksum(ck[0]), .out_ok(ok_o[0]), .out_err(er[0]));

    ipv4_hdr_chksum_stream #(.DW(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(d16),
        .in_last(il[1]), .in_mode(im[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_chksum(ck[1]), .out_ok(ok_o[1]), .out_err(er[1]));

    ipv4_hdr_chksum_stream #(.DW(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(d64),
        .in_last(il[2]), .in_mode(im[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_chksum(ck[2]), .out_ok(ok_o[2]), .out_err(er[2]));

    function automatic int lanes_of(input int idx);
        return (idx == 0) ? 2 : (idx == 1) ? 1 : 4;
    endfunction

    // Reference: plain 16-bit word sum, end-around carries until none remain, at most 15 beats counted.
    function automatic void model(input logic [15:0] w[$], input int lanes, input logic mode,
                                  output logic [15:0] chk, output logic okv, output logic errv);
        int     nb;
        int     minb;
        longint s;
        nb   = (w.size() + lanes - 1) / lanes;
        minb = (10 + lanes - 1) / lanes;
        errv = (nb < minb) || (nb > 15);
        s    = 0;
        foreach (w[i]) begin
            if (i < 15 * lanes && !(mode == 1'b0 && i == 5)) s += longint'(w[i]);
        end
        while (s > 64'hFFFF) s = (s & 64'hFFFF) + (s >> 16);
        okv = !errv && (mode ? (s == 64'hFFFF) : 1'b1);
        chk = ~s[15:0];
    endfunction

    task automatic send_hdr(input int idx, input logic [15:0] w[$], input logic mode,
                            input int max_send, output int stalls);
        int           lanes;
        int           nb;
        int           lim;
        int           k;
        int           t;
        logic         got;
        logic [127:0] d;
        lanes  = lanes_of(idx);
        nb     = (w.size() + lanes - 1) / lanes;
        lim    = (max_send < nb) ? max_send : nb;
        stalls = 0;
        for (int b = 0; b < lim; b++) begin
            d = '0;
            for (int p = 0; p < lanes; p++) begin
                k = b * lanes + p;
                d = {d[111:0], (k < w.size()) ? w[k] : 16'h0000};
            end
            case (idx)
                0:       d32 = d[31:0];
                1:       d16 = d[15:0];
                default: d64 = d[63:0];
            endcase
            iv[idx] = 1'b1;
            il[idx] = (b == nb - 1);
            im[idx] = mode;
            t   = 0;
            got = 1'b0;
            while (!got && t < 50) begin
                got = ir[idx];
                @(posedge clk);
                #1;
                if (!got) begin
                    stalls++;
                    t++;
                end
            end
            if (!got) begin
                checks++;
                errors++;
                $display("[TB] FAIL beat_accept: dut %0d beat %0d never accepted", idx, b);
            end
        end
        iv[idx] = 1'b0;
        il[idx] = 1'b0;
        im[idx] = 1'($urandom);
        d32 = $urandom;
        d16 = 16'($urandom);
        d64 = {$urandom, $urandom};
    endtask

    task automatic wait_out(input int idx, output int n);
        n = 0;
        while (!ov[idx] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ov[idx]) n = -1;
    endtask

    task automatic take(input int idx);
        ordy[idx] = 1'b1;
        @(posedge clk);
        #1;
        ordy[idx] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ir[0] !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", ir[0]); end
        checks++;
        if (ov[0] !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", ov[0]); end
        checks++;
        if (ck[0] !== 16'h0000) begin errors++; $display("[TB] FAIL reset_chksum: got %h expected 0000", ck[0]); end
        checks++;
        if (ok_o[0] !== 1'b0 || er[0] !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_flags: got ok=%b err=%b expected 0 0", ok_o[0], er[0]);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ir[0] !== 1'b1 || ir[1] !== 1'b1 || ir[2] !== 1'b1) begin
            errors++; $display("[TB] FAIL idle_ready: got %b%b%b expected 111", ir[0], ir[1], ir[2]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_generate();
        logic [15:0] w[$];
        int          st;
        int          n;
        w = ref_hdr;
        for (int v = 0; v < 2; v++) begin
            if (v == 1) w[5] = 16'h0000;
            send_hdr(0, w, 1'b0, 99, st);
            wait_out(0, n);
            // out_valid appears in the third cycle after the acceptance cycle, i.e. after two more edges.
            checks++;
            if (n !== 2) begin errors++; $display("[TB] FAIL gen_latency: got %0d edges expected 2", n); end
            checks++;
            if (ck[0] !== 16'hB861) begin errors++; $display("[TB] FAIL gen_chksum: got %h expected b861", ck[0]); end
            checks++;
            if (ok_o[0] !== 1'b1 || er[0] !== 1'b0) begin
                errors++; $display("[TB] FAIL gen_flags: got ok=%b err=%b expected 1 0", ok_o[0], er[0]);
            end
            checks++;
            if (st !== 0) begin errors++; $display("[TB] FAIL gen_stalls: got %0d expected 0", st); end
            take(0);
        end
    endtask

    task automatic test_verify();
        logic [15:0] w[$];
        logic [15:0] ec;
        logic        eo;
        logic        ee;
        int          st;
        int          n;
        w = ref_hdr;
        send_hdr(0, w, 1'b1, 99, st);
        wait_out(0, n);
        checks++;
        if (ck[0] !== 16'h0000 || ok_o[0] !== 1'b1 || er[0] !== 1'b0) begin
            errors++; $display("[TB] FAIL verify_good: got %h ok=%b err=%b expected 0000 1 0", ck[0], ok_o[0], er[0]);
        end
        take(0);
        w[7] = 16'h0002;
        model(w, 2, 1'b1, ec, eo, ee);
        send_hdr(0, w, 1'b1, 99, st);
        wait_out(0, n);
        checks++;
        if (ok_o[0] !== 1'b0) begin errors++; $display("[TB] FAIL verify_bad_ok: got %b expected 0", ok_o[0]); end
        checks++;
        if (ck[0] !== ec) begin errors++; $display("[TB] FAIL verify_bad_chksum: got %h expected %h", ck[0], ec); end
        take(0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] w[$];
        logic [15:0] ec;
        logic        eo;
        logic        ee;
        int          st;
        int          n;
        w = {};
        for (int i = 0; i < 12; i++) w.push_back(16'($urandom));
        model(w, 2, 1'b0, ec, eo, ee);
        send_hdr(0, w, 1'b0, 99, st);
        wait_out(0, n);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (ov[0] !== 1'b1 || ck[0] !== ec || ok_o[0] !== eo || er[0] !== ee || ir[0] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_stable: cycle %0d got v=%b ck=%h ok=%b err=%b rdy=%b expected 1 %h %b %b 0",
                         c, ov[0], ck[0], ok_o[0], er[0], ir[0], ec, eo, ee);
            end
            @(posedge clk);
            #1;
        end
        take(0);
        checks++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
            errors++; $display("[TB] FAIL release_idle: got v=%b rdy=%b expected 0 1", ov[0], ir[0]);
        end
        w = {};
        for (int i = 0; i < 10; i++) w.push_back(16'($urandom));
        model(w, 2, 1'b0, ec, eo, ee);
        w[5] = ec;
        model(w, 2, 1'b1, ec, eo, ee);
        send_hdr(0, w, 1'b1, 99, st);
        wait_out(0, n);
        checks++;
        if (ck[0] !== 16'h0000 || ck[0] !== ec || ok_o[0] !== 1'b1 || eo !== 1'b1) begin
            errors++; $display("[TB] FAIL second_hdr: got %h ok=%b expected %h 1", ck[0], ok_o[0], ec);
        end
        take(0);
    endtask

    task automatic test_errors();
        logic [15:0] w[$];
        logic [15:0] ec;
        logic        eo;
        logic        ee;
        int          st;
        int          n;
        for (int v = 0; v < 2; v++) begin
            w = {};
            for (int i = 0; i < ((v == 0) ? 32 : 6); i++) w.push_back(16'($urandom));
            model(w, 2, 1'b1, ec, eo, ee);
            send_hdr(0, w, 1'b1, 99, st);
            wait_out(0, n);
            checks++;
            if (er[0] !== 1'b1 || ok_o[0] !== 1'b0 || ee !== 1'b1) begin
                errors++; $display("[TB] FAIL err_flags_%0d: got err=%b ok=%b expected 1 0", v, er[0], ok_o[0]);
            end
            checks++;
            if (ck[0] !== ec) begin errors++; $display("[TB] FAIL err_chksum_%0d: got %h expected %h", v, ck[0], ec); end
            checks++;
            if (st !== 0) begin errors++; $display("[TB] FAIL err_stalls_%0d: got %0d expected 0", v, st); end
            take(0);
            checks++;
            if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
                errors++; $display("[TB] FAIL err_handshake_%0d: got v=%b rdy=%b expected 0 1", v, ov[0], ir[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int st;
        int n;
        int seen;
        send_hdr(0, ref_hdr, 1'b0, 3, st);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (ov[0]) seen++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("[TB] FAIL reset_mid_valid: got %0d valid cycles expected 0", seen); end
        send_hdr(0, ref_hdr, 1'b0, 99, st);
        wait_out(0, n);
        checks++;
        if (ck[0] !== 16'hB861 || ok_o[0] !== 1'b1 || er[0] !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_mid_next: got %h ok=%b err=%b expected b861 1 0", ck[0], ok_o[0], er[0]);
        end
        take(0);
    endtask

    task automatic test_random(input int idx, input int iters);
        logic [15:0] w[$];
        logic [15:0] ec;
        logic        eo;
        logic        ee;
        logic        mode;
        int          lanes;
        int          nb;
        int          st;
        int          n;
        lanes = lanes_of(idx);
        for (int it = 0; it < iters; it++) begin
            nb   = $urandom_range((10 + lanes - 1) / lanes, 15);
            mode = 1'($urandom);
            w    = {};
            for (int i = 0; i < nb * lanes; i++) w.push_back(16'($urandom));
            if (mode && $urandom_range(0, 1) == 1) begin
                model(w, lanes, 1'b0, ec, eo, ee);
                w[5] = ec;
            end
            model(w, lanes, mode, ec, eo, ee);
            send_hdr(idx, w, mode, 99, st);
            wait_out(idx, n);
            checks++;
            if (n !== 2 || ck[idx] !== ec || ok_o[idx] !== eo || er[idx] !== ee) begin
                errors++;
                $display("[TB] FAIL random_%0d_%0d: got n=%0d ck=%h ok=%b err=%b expected 2 %h %b %b",
                         idx, it, n, ck[idx], ok_o[idx], er[idx], ec, eo, ee);
            end
            take(idx);
        end
    endtask

    task automatic test_param_sweep();
        int st;
        int n;
        for (int idx = 1; idx < 3; idx++) begin
            send_hdr(idx, ref_hdr, 1'b0, 99, st);
            wait_out(idx, n);
            checks++;
            if (ck[idx] !== 16'hB861 || ok_o[idx] !== 1'b1 || er[idx] !== 1'b0) begin
                errors++; $display("[TB] FAIL sweep_gen_%0d: got %h ok=%b err=%b expected b861 1 0", idx, ck[idx], ok_o[idx], er[idx]);
            end
            take(idx);
            send_hdr(idx, ref_hdr, 1'b1, 99, st);
            wait_out(idx, n);
            checks++;
            if (ck[idx] !== 16'h0000 || ok_o[idx] !== 1'b1) begin
                errors++; $display("[TB] FAIL sweep_verify_%0d: got %h ok=%b expected 0000 1", idx, ck[idx], ok_o[idx]);
            end
            take(idx);
            test_random(idx, 10);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            iv[i]   = 1'b0;
            il[i]   = 1'b0;
            im[i]   = 1'b0;
            ordy[i] = 1'b0;
        end
        d32 = '0;
        d16 = '0;
        d64 = '0;
        rst = 1'b1;
        test_reset();
        test_generate();
        test_verify();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        test_random(0, 30);
        test_param_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
